// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller in front of an 8-bit ALU.
// Fetches instruction words, sequences ALU operations against a 4-entry
// register file, and streams register values out over valid/ready.
module alu_sequencer #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] REG_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [7:0]        instr_data,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              carry_flag,
    output logic              busy
);

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpInc  = 4'h3;
    localparam logic [3:0] OpLdi  = 4'h4;
    localparam logic [3:0] OpMov  = 4'h5;
    localparam logic [3:0] OpOut  = 4'h6;
    // Opcode the ALU treats as "no operation, output 0".
    localparam logic [3:0] OpIdle = 4'hF;

    typedef enum logic [1:0] {StFetch, StExec, StImm, StOut} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];
    logic              carry_q, carry_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic [1:0]        rs_q, rs_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs;

    assign in_op = instr_data[7:4];
    assign in_rd = instr_data[3:2];
    assign in_rs = instr_data[1:0];

    // Next-state, register-file write and ALU drive decode.
    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        carry_d     = carry_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        instr_ready = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_opcode  = OpIdle;

        unique case (state_q)
            StFetch: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    case (in_op)
                        OpAdd, OpSub, OpAnd, OpInc: begin
                            op_d    = in_op;
                            rd_d    = in_rd;
                            rs_d    = in_rs;
                            state_d = StExec;
                        end
                        OpLdi: begin
                            rd_d    = in_rd;
                            state_d = StImm;
                        end
                        OpMov: begin
                            rf_d[in_rd] = rf_q[in_rs];
                        end
                        OpOut: begin
                            out_data_d  = rf_q[in_rd];
                            out_valid_d = 1'b1;
                            state_d     = StOut;
                        end
                        default: ; // 7..15 are NOPs
                    endcase
                end
            end
            StExec: begin
                alu_a       = rf_q[rd_q];
                alu_b       = rf_q[rs_q];
                alu_opcode  = op_q;
                rf_d[rd_q]  = alu_result;
                carry_d     = alu_carry;
                state_d     = StFetch;
            end
            StImm: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    rf_d[rd_q] = instr_data;
                    state_d    = StFetch;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // State and architectural registers; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            for (int i = 0; i < 4; i++) rf_q[i] <= REG_RESET;
            carry_q     <= 1'b0;
            op_q        <= OpIdle;
            rd_q        <= '0;
            rs_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign carry_flag = carry_q;
    assign busy       = (state_q != StFetch);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level register model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_opcode;
    logic       alu_carry;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       carry_flag;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Instruction-level reference state.
    logic [7:0] m_rf [4];
    logic       m_carry;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(8), .REG_RESET(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_ready(instr_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .carry_flag (carry_flag),
        .busy       (busy)
    );

    // Stand-in for the downstream 8-bit ALU.
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_opcode)
            4'h0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h1: begin
                alu_result = alu_a - alu_b;
                alu_carry  = (alu_a >= alu_b);
            end
            4'h2: alu_result = alu_a & alu_b;
            4'h3: {alu_carry, alu_result} = {1'b0, alu_a} + 9'd1;
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ins(input int op, input int rd, input int rs);
        logic [3:0] o = op[3:0];
        logic [1:0] d = rd[1:0];
        logic [1:0] s = rs[1:0];
        return {o, d, s};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_carry = 1'b0;
    endtask

    task automatic model_alu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs);
        int a = int'(m_rf[rd]);
        int b = int'(m_rf[rs]);
        int r;
        case (op)
            4'h0: begin r = a + b; m_carry = (r > 255); end
            4'h1: begin r = a - b; m_carry = (a >= b); end
            4'h2: begin r = a & b; m_carry = 1'b0; end
            default: begin r = a + 1; m_carry = (r > 255); end
        endcase
        m_rf[rd] = r[7:0];
    endtask

    // Present one word and return at the negedge after it was accepted.
    task automatic push(input logic [7:0] w);
        int n = 0;
        instr_valid = 1'b1;
        instr_data  = w;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Hold out_ready low for 'hold' cycles, then complete one transfer.
    task automatic drain_out(input logic [7:0] exp, input int hold);
        for (int k = 0; k < hold; k++) begin
            check_eq("out_valid_hold", {31'd0, out_valid}, 32'd1);
            check_eq("out_data_hold", {24'd0, out_data}, {24'd0, exp});
            check_eq("out_ready_block", {31'd0, instr_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check_eq("out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("out_data", {24'd0, out_data}, {24'd0, exp});
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("out_done_valid", {31'd0, out_valid}, 32'd0);
        check_eq("out_done_ready", {31'd0, instr_ready}, 32'd1);
    endtask

    // Issue one instruction (with its immediate for LDI) and check the result.
    task automatic run(input logic [7:0] w, input logic [7:0] imm, input int hold);
        logic [3:0] op = w[7:4];
        logic [1:0] rd = w[3:2];
        logic [1:0] rs = w[1:0];
        push(w);
        if (op <= 4'h3) begin
            check_eq("exec_ready", {31'd0, instr_ready}, 32'd0);
            check_eq("exec_busy", {31'd0, busy}, 32'd1);
            check_eq("exec_opcode", {28'd0, alu_opcode}, {28'd0, op});
            check_eq("exec_a", {24'd0, alu_a}, {24'd0, m_rf[rd]});
            check_eq("exec_b", {24'd0, alu_b}, {24'd0, m_rf[rs]});
            @(negedge clk);
            model_alu(op, rd, rs);
        end else if (op == 4'h4) begin
            check_eq("imm_ready", {31'd0, instr_ready}, 32'd1);
            check_eq("imm_busy", {31'd0, busy}, 32'd1);
            push(imm);
            m_rf[rd] = imm;
        end else if (op == 4'h5) begin
            m_rf[rd] = m_rf[rs];
        end else if (op == 4'h6) begin
            drain_out(m_rf[rd], hold);
        end
        check_eq("carry", {31'd0, carry_flag}, {31'd0, m_carry});
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_opcode", {28'd0, alu_opcode}, 32'hF);
    endtask

    task automatic dump_regs();
        for (int i = 0; i < 4; i++) run(ins(6, i, 0), 8'h00, 0);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
        out_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_carry", {31'd0, carry_flag}, 32'd0);
        check_eq("rst_alu_a", {24'd0, alu_a}, 32'd0);
        dump_regs();

        // ADD with carry out.
        run(ins(4, 0, 0), 8'hF0, 0);
        run(ins(4, 1, 0), 8'h20, 0);
        run(ins(0, 0, 1), 8'h00, 0);
        run(ins(6, 0, 0), 8'h00, 0);

        // SUB borrow cases and rd==rs.
        run(ins(4, 2, 0), 8'h05, 0);
        run(ins(4, 3, 0), 8'h07, 0);
        run(ins(1, 2, 3), 8'h00, 0);
        run(ins(6, 2, 0), 8'h00, 1);
        run(ins(1, 3, 2), 8'h00, 0);
        run(ins(6, 3, 0), 8'h00, 0);
        run(ins(4, 3, 0), 8'h07, 0);
        run(ins(1, 3, 3), 8'h00, 0);
        run(ins(6, 3, 0), 8'h00, 0);

        // INC wrap, AND clears carry, MOV/LDI/OUT keep carry.
        run(ins(4, 1, 0), 8'hFF, 0);
        run(ins(3, 1, 2), 8'h00, 0);
        run(ins(2, 1, 1), 8'h00, 0);
        run(ins(5, 2, 1), 8'h00, 0);
        run(ins(4, 0, 0), 8'h3C, 0);
        run(ins(6, 0, 0), 8'h00, 0);
        dump_regs();

        // Output back-pressure for 5 cycles.
        run(ins(6, 0, 0), 8'h00, 5);

        // Out_ready already high on entry.
        out_ready = 1'b1;
        push(ins(6, 2, 0));
        check_eq("fast_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("fast_out_data", {24'd0, out_data}, {24'd0, m_rf[2]});
        @(negedge clk);
        check_eq("fast_out_done", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset while waiting for an immediate.
        run(ins(4, 0, 0), 8'h55, 0);
        push(ins(4, 0, 0));
        instr_valid = 1'b1;
        instr_data  = 8'hAA;
        rst         = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b0;
        model_reset();
        check_eq("imm_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("imm_rst_ready", {31'd0, instr_ready}, 32'd1);
        run(ins(6, 0, 0), 8'h00, 0);

        // Reset during EXEC after carry was set.
        run(ins(4, 0, 0), 8'hFF, 0);
        run(ins(3, 0, 0), 8'h00, 0);
        run(ins(4, 0, 0), 8'hFF, 0);
        push(ins(3, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("exec_rst_carry", {31'd0, carry_flag}, 32'd0);
        check_eq("exec_rst_busy", {31'd0, busy}, 32'd0);
        dump_regs();

        // NOPs leave everything untouched.
        run(ins(4, 1, 0), 8'h81, 0);
        run(ins(4, 2, 0), 8'h92, 0);
        run(ins(0, 1, 2), 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] w = $urandom;
            w[7:4] = (i % 2 == 0) ? 4'hB : 4'h7;
            run(w, 8'h00, 0);
            check_eq("nop_out_valid", {31'd0, out_valid}, 32'd0);
            check_eq("nop_ready", {31'd0, instr_ready}, 32'd1);
        end
        dump_regs();

        // Back-to-back ADDs with instr_valid held high.
        run(ins(4, 0, 0), 8'h03, 0);
        run(ins(4, 1, 0), 8'h04, 0);
        instr_valid = 1'b1;
        instr_data  = ins(0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            check_eq("b2b_ready", {31'd0, instr_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        model_alu(4'h0, 2'd0, 2'd1);
        model_alu(4'h0, 2'd0, 2'd1);
        check_eq("b2b_carry", {31'd0, carry_flag}, {31'd0, m_carry});
        run(ins(6, 0, 0), 8'h00, 0);

        // Random instruction stream.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] w   = $urandom;
            logic [7:0] imm = $urandom;
            if ($urandom_range(0, 3) == 0) w[7:4] = 4'h6;
            else if ($urandom_range(0, 2) == 0) w[7:4] = 4'h4;
            run(w, imm, $urandom_range(0, 3));
        end
        dump_regs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle execute controller that sits directly upstream of the 8-bit ALU (ADD/SUB/AND/INC, 4-bit opcode, carry_out).
- Accepts 8-bit instruction words over a valid/ready handshake and holds a 4 x 8-bit register file plus a carry flag.
- Drives the ALU operand and opcode ports, then writes the ALU result and carry back.
- Emits register contents on an output valid/ready stream.

Parameters:
- DATA_W, 8, datapath width; only 8 is supported (must match the ALU).
- REG_RESET, 8'h00, reset value loaded into every register-file entry.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction/immediate word valid.
- instr_data  in  8  instruction word: [7:4] op, [3:2] rd, [1:0] rs; in IMM state, the immediate byte.
- instr_ready  out  1  sequencer can accept instr_data this cycle.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_opcode  out  4  ALU opcode.
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_opcode).
- alu_carry  in  1  ALU carry_out.
- out_valid  out  1  out_data valid.
- out_data  out  8  register value being emitted.
- out_ready  in  1  downstream accepts out_data.
- carry_flag  out  1  architectural carry flag.
- busy  out  1  high in any state other than FETCH.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on ports clk/rst.
- Reset: state=FETCH, all regs=REG_RESET, carry_flag=0, out_valid=0, out_data=0, busy=0.
  - Reset wins over any simultaneous handshake.
  - Reset mid-operation (EXEC/IMM/OUT) abandons the operation with no write-back.
- Op decode (instr_data[7:4]):
  - 0 ADD, 1 SUB, 2 AND, 3 INC: ALU ops.
  - 4 LDI.
  - 5 MOV.
  - 6 OUT.
  - 7-15 NOP: accepted, no state change.
- FETCH:
  - instr_ready=1; a transfer is instr_valid & instr_ready.
  - ALU op: latch op/rd/rs, go to EXEC.
  - LDI: latch rd, go to IMM.
  - MOV: reg[rd] <= reg[rs] in the same edge, stay in FETCH.
  - OUT: out_data <= reg[rd], out_valid <= 1, go to OUT.
  - NOP: stay in FETCH.
- EXEC (exactly 1 cycle):
  - instr_ready=0; alu_a=reg[rd], alu_b=reg[rs], alu_opcode=latched op.
  - End of cycle: reg[rd] <= alu_result, carry_flag <= alu_carry, return to FETCH.
  - INC ignores alu_b; AND writes carry_flag=0 (the ALU returns 0).
  - Throughput: one ALU op per 2 cycles. Result visible in reg[rd] the cycle after EXEC.
- Outside EXEC: alu_a=0, alu_b=0, alu_opcode=4'hF, which the ALU treats as default and outputs 0.
- IMM:
  - instr_ready=1; on transfer reg[rd] <= instr_data, return to FETCH.
  - Waits indefinitely with no timeout.
- OUT:
  - instr_ready=0; out_valid stays 1 and out_data stays stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, return to FETCH.
  - out_ready already high on entry: completes after 1 cycle in OUT.
- Register aliasing:
  - rd==rs is legal (e.g. ADD r1,r1 doubles r1).
  - MOV rd==rs is a no-op.
- Flag rules:
  - carry_flag changes only on the EXEC write-back or on reset.
  - LDI, MOV, OUT and NOP leave it unchanged.
- Arithmetic is 8-bit wrap-around, performed by the ALU. SUB carry = NOT borrow, as the ALU supplies it.

Test Plan:
- LDI r0,0xF0; LDI r1,0x20; ADD r0,r1; OUT r0 -> out_data=0x10, carry_flag=1, EXEC exactly 1 cycle with instr_ready=0.
- LDI r2,0x05; LDI r3,0x07; SUB r2,r3; OUT r2 -> out_data=0xFE, carry_flag=0. Then SUB r3,r2 (0x07-0xFE) -> r3=0x09, carry_flag=0. Then LDI r3,0x07; SUB r3,r3 -> 0x00, carry_flag=1.
- LDI r1,0xFF; INC r1 -> r1=0x00, carry_flag=1. Then AND r1,r1 -> r1=0x00, carry_flag=0. Then MOV r2,r1; LDI r0,0x3C; OUT r0 -> 0x3C, carry_flag still 0.
- OUT r0 with out_ready held low 5 cycles -> out_valid high and out_data stable all 5 cycles, instr_ready=0. Raise out_ready -> one transfer, then instr_ready=1 next cycle.
- LDI r0 accepted, then rst asserted while in IMM with instr_valid high (data 0xAA) -> r0=0x00, state FETCH, no write of 0xAA. Also assert rst during an EXEC cycle -> no write-back, carry_flag=0.
- Op 0xB (NOP) and op 0x7 with random rd/rs -> accepted in 1 cycle, all registers, carry_flag and out_valid unchanged. Back-to-back ADDs with instr_valid held high -> instr_ready toggles 1,0,1,0.
